// File: rtl/i2s_mstr_tx_if.sv
// Sample-side bus of the I2S master transmitter, plus the serial I2S pins.
//
// master : sample producer (full-chip bench, audio source). Drives wrt and
//          the sample pair, observes buffer status and the I2S pins.
// slave  : the transmitter itself. Consumes samples, drives status and pins.
//
// Signals
//   wrt        one-clk strobe offering lft_smpl/rght_smpl
//   lft_smpl   24-bit signed left sample
//   rght_smpl  24-bit signed right sample
//   buf_full   write buffer holds an untransferred pair (wrt ignored)
//   undrrn     one-clk pulse at a frame start with an empty buffer
//   frm_strt   one-clk pulse at every frame start
//   I2S_sclk   bit clock, clk/32
//   I2S_ws     word select, 0 = left, 1 = right
//   I2S_data   serial data, MSB first
interface i2s_mstr_tx_if;
  logic        wrt;
  logic [23:0] lft_smpl;
  logic [23:0] rght_smpl;
  logic        buf_full;
  logic        undrrn;
  logic        frm_strt;
  logic        I2S_sclk;
  logic        I2S_ws;
  logic        I2S_data;

  modport master (
    output wrt, lft_smpl, rght_smpl,
    input  buf_full, undrrn, frm_strt, I2S_sclk, I2S_ws, I2S_data
  );

  modport slave (
    input  wrt, lft_smpl, rght_smpl,
    output buf_full, undrrn, frm_strt, I2S_sclk, I2S_ws, I2S_data
  );
endinterface

// File: rtl/i2s_mstr_tx.sv
// I2S master transmitter, Philips format, 24-bit samples in 32-bit slots.
//
// A one-deep write buffer accepts left/right pairs; at each frame start
// (bit period 63 -> 0) the buffered pair is copied into the holding
// registers that feed the serializer. With nothing buffered, the previous
// pair repeats and undrrn pulses.
//
// Ports
//   clk       system clock (50 MHz), all logic on posedge
//   rst_n     asynchronous active-low reset
//   smpl_bus  i2s_mstr_tx_if.slave: wrt/lft_smpl/rght_smpl in,
//             buf_full/undrrn/frm_strt/I2S_sclk/I2S_ws/I2S_data out
//
// Timing: bit clock = clk/32, 64 bit clocks per stereo frame (2048 clks).
// I2S_ws and I2S_data change only on the clk edge where sclk_cnt wraps
// 31 -> 0 (the I2S_sclk falling edge), 16 clks ahead of the next rising edge.
module i2s_mstr_tx (
  input  logic          clk,
  input  logic          rst_n,
  i2s_mstr_tx_if.slave  smpl_bus
);

  logic [4:0]  sclk_cnt;
  logic [5:0]  bit_cnt;
  logic [4:0]  sclk_nxt;
  logic [5:0]  bit_nxt;

  logic [23:0] lft_buf;
  logic [23:0] rght_buf;
  logic [23:0] lft_shft;
  logic [23:0] rght_shft;

  logic        buf_full_q;
  logic        undrrn_q;
  logic        frm_strt_q;
  logic        sclk_q;
  logic        ws_q;
  logic        data_q;

  logic        fall;
  logic        xfer;
  logic        accept;
  logic        data_nxt;
  logic [4:0]  lft_idx;
  logic [4:0]  rght_idx;

  // Data for the bit period being entered on this fall. Periods 1-24 carry
  // left[23:0] and 33-56 right[23:0]; everything else is padding zeros,
  // which also provides the one-bit delay after each ws transition.
  // Indexing (rather than shifting) keeps the holding registers untouched
  // for the whole frame.
  always_comb begin
    sclk_nxt = sclk_cnt + 5'd1;
    bit_nxt  = bit_cnt + 6'd1;
    fall     = (sclk_cnt == 5'd31);
    xfer     = fall && (bit_cnt == 6'd63);
    accept   = smpl_bus.wrt && !buf_full_q;
    lft_idx  = 5'(6'd24 - bit_nxt);
    rght_idx = 5'(6'd56 - bit_nxt);
    data_nxt = 1'b0;
    if ((bit_nxt >= 6'd1) && (bit_nxt <= 6'd24)) begin
      data_nxt = lft_shft[lft_idx];
    end else if ((bit_nxt >= 6'd33) && (bit_nxt <= 6'd56)) begin
      data_nxt = rght_shft[rght_idx];
    end
  end

  // Bit clock and frame timing. I2S_sclk is loaded from the next count so
  // that it always equals sclk_cnt[4].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_cnt <= 5'd0;
      sclk_q   <= 1'b0;
      bit_cnt  <= 6'd0;
      ws_q     <= 1'b0;
      data_q   <= 1'b0;
    end else begin
      sclk_cnt <= sclk_nxt;
      sclk_q   <= sclk_nxt[4];
      if (fall) begin
        bit_cnt <= bit_nxt;
        ws_q    <= bit_nxt[5];
        data_q  <= data_nxt;
      end
    end
  end

  // Write buffer. A write accepted on a transfer edge with an empty buffer
  // still lands here; the transfer sees the old (empty) state, so the new
  // pair waits one more frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_buf    <= 24'd0;
      rght_buf   <= 24'd0;
      buf_full_q <= 1'b0;
    end else begin
      if (accept) begin
        lft_buf  <= smpl_bus.lft_smpl;
        rght_buf <= smpl_bus.rght_smpl;
      end
      if (xfer && buf_full_q) begin
        buf_full_q <= 1'b0;
      end else if (accept) begin
        buf_full_q <= 1'b1;
      end
    end
  end

  // Holding registers change only on the transfer edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_shft  <= 24'd0;
      rght_shft <= 24'd0;
    end else if (xfer && buf_full_q) begin
      lft_shft  <= lft_buf;
      rght_shft <= rght_buf;
    end
  end

  // Frame-start status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      undrrn_q   <= 1'b0;
      frm_strt_q <= 1'b0;
    end else begin
      undrrn_q   <= xfer && !buf_full_q;
      frm_strt_q <= xfer;
    end
  end

  assign smpl_bus.buf_full = buf_full_q;
  assign smpl_bus.undrrn   = undrrn_q;
  assign smpl_bus.frm_strt = frm_strt_q;
  assign smpl_bus.I2S_sclk = sclk_q;
  assign smpl_bus.I2S_ws   = ws_q;
  assign smpl_bus.I2S_data = data_q;

endmodule

// File: tb/tb_i2s_mstr_tx.sv
// Bench for i2s_mstr_tx. Time is tracked as t = posedges since reset release;
// expected pins are computed from t and the pair currently being transmitted.
// A behavioural I2S receiver deserializes the pins on I2S_sclk rising edges.
module tb_i2s_mstr_tx;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2s_mstr_tx_if bus ();

  i2s_mstr_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .smpl_bus (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int unsigned t        = 0;

  // transaction-level model of buffer / holding pair
  logic [47:0] mdl_buf    = '0;
  logic [47:0] mdl_hold   = '0;
  logic        mdl_full   = 1'b0;
  logic        exp_undrrn = 1'b0;
  logic        exp_frm    = 1'b0;

  // receiver
  logic [47:0] rx_q[$];
  int          rx_idx     = -1;
  logic        rx_prev_ws = 1'b0;
  logic [23:0] rx_l       = '0;
  logic [23:0] rx_r       = '0;

  function automatic logic exp_sclk();
    return ((t % 32) >= 16);
  endfunction

  function automatic logic exp_ws();
    return (((t / 32) % 64) >= 32);
  endfunction

  function automatic logic exp_data();
    int p;
    p = int'((t / 32) % 64);
    if (p >= 1 && p <= 24) return mdl_hold[48 - p];
    if (p >= 33 && p <= 56) return mdl_hold[56 - p];
    return 1'b0;
  endfunction

  always @(posedge bus.I2S_sclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_idx     = -1;
      rx_prev_ws = 1'b0;
    end else begin
      if (bus.I2S_ws !== rx_prev_ws) rx_idx = 0;
      else rx_idx++;
      rx_prev_ws = bus.I2S_ws;
      if (rx_idx >= 1 && rx_idx <= 24) begin
        if (bus.I2S_ws) rx_r = {rx_r[22:0], bus.I2S_data};
        else            rx_l = {rx_l[22:0], bus.I2S_data};
      end
      if (bus.I2S_ws && rx_idx == 24) rx_q.push_back({rx_l, rx_r});
    end
  end

  // One clk: drive inputs, take the edge, advance the model, sample at +1.
  task automatic tick(input logic w, input logic [23:0] l, input logic [23:0] r);
    logic xfer, f;
    bus.wrt       = w;
    bus.lft_smpl  = l;
    bus.rght_smpl = r;
    @(posedge clk);
    t++;
    xfer       = (t % 2048 == 0);
    f          = mdl_full;
    exp_undrrn = xfer && !f;
    exp_frm    = xfer;
    if (xfer && f) begin
      mdl_hold = mdl_buf;
      mdl_full = 1'b0;
    end else if (w && !f) begin
      mdl_buf  = {l, r};
      mdl_full = 1'b1;
    end
    #1;
    bus.wrt = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    t          = 0;
    mdl_buf    = '0;
    mdl_hold   = '0;
    mdl_full   = 1'b0;
    exp_undrrn = 1'b0;
    exp_frm    = 1'b0;
    rx_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (bus.I2S_sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got %b want 0", bus.I2S_sclk); end
    if (bus.I2S_ws   !== 1'b0) begin failures++; $display("FAIL reset_ws got %b want 0", bus.I2S_ws); end
    if (bus.I2S_data !== 1'b0) begin failures++; $display("FAIL reset_data got %b want 0", bus.I2S_data); end
    if (bus.buf_full !== 1'b0) begin failures++; $display("FAIL reset_buf_full got %b want 0", bus.buf_full); end
    if (bus.undrrn   !== 1'b0) begin failures++; $display("FAIL reset_undrrn got %b want 0", bus.undrrn); end
    if (bus.frm_strt !== 1'b0) begin failures++; $display("FAIL reset_frm_strt got %b want 0", bus.frm_strt); end
    release_reset();
  endtask

  task automatic test_idle();
    int n_und = 0;
    for (int i = 0; i < 4100; i++) begin
      tick(1'b0, 24'd0, 24'd0);
      if (bus.undrrn === 1'b1) n_und++;
      checks += 5;
      if (bus.I2S_sclk !== exp_sclk()) begin failures++; $display("FAIL idle_sclk t=%0d got %b want %b", t, bus.I2S_sclk, exp_sclk()); end
      if (bus.I2S_ws !== exp_ws()) begin failures++; $display("FAIL idle_ws t=%0d got %b want %b", t, bus.I2S_ws, exp_ws()); end
      if (bus.I2S_data !== 1'b0) begin failures++; $display("FAIL idle_data t=%0d got %b want 0", t, bus.I2S_data); end
      if (bus.undrrn !== exp_undrrn) begin failures++; $display("FAIL idle_undrrn t=%0d got %b want %b", t, bus.undrrn, exp_undrrn); end
      if (bus.frm_strt !== exp_frm) begin failures++; $display("FAIL idle_frm_strt t=%0d got %b want %b", t, bus.frm_strt, exp_frm); end
    end
    checks++;
    if (n_und != 2) begin failures++; $display("FAIL idle_undrrn_count got %0d want 2", n_und); end
  endtask

  task automatic test_first_frame();
    #2 rst_n = 1'b0;
    release_reset();
    tick(1'b1, 24'hA5F00F, 24'h5A0FF0);
    checks++;
    if (bus.buf_full !== 1'b1) begin failures++; $display("FAIL ff_buf_full_set got %b want 1", bus.buf_full); end
    while (t < 2047) tick(1'b0, 24'd0, 24'd0);
    tick(1'b0, 24'd0, 24'd0);
    checks += 3;
    if (bus.frm_strt !== 1'b1) begin failures++; $display("FAIL ff_frm_strt t=%0d got %b want 1", t, bus.frm_strt); end
    if (bus.undrrn !== 1'b0) begin failures++; $display("FAIL ff_undrrn t=%0d got %b want 0", t, bus.undrrn); end
    if (bus.buf_full !== 1'b0) begin failures++; $display("FAIL ff_buf_full_clr t=%0d got %b want 0", t, bus.buf_full); end
    for (int i = 0; i < 3000 && rx_q.size() < 2; i++) tick(1'b0, 24'd0, 24'd0);
    checks++;
    if (rx_q.size() < 2) begin
      failures++; $display("FAIL ff_rx_timeout got %0d frames want 2", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 48'h0) begin failures++; $display("FAIL ff_frame0 got %h want 0", rx_q[0]); end
      if (rx_q[1] !== 48'hA5F00F_5A0FF0) begin failures++; $display("FAIL ff_frame1 got %h want a5f00f5a0ff0", rx_q[1]); end
    end
  endtask

  task automatic test_drop();
    logic [23:0] l1, r1, l2, r2;
    int f;
    l1 = 24'($urandom); r1 = 24'($urandom);
    l2 = ~l1;           r2 = ~r1;
    tick(1'b1, l1, r1);
    f = int'(t / 2048) + 1;
    repeat (5) tick(1'b0, 24'd0, 24'd0);
    tick(1'b1, l2, r2);
    checks++;
    if (bus.buf_full !== 1'b1) begin failures++; $display("FAIL drop_buf_full got %b want 1", bus.buf_full); end
    for (int i = 0; i < 6000 && rx_q.size() <= f; i++) tick(1'b0, 24'd0, 24'd0);
    checks++;
    if (rx_q.size() <= f) begin
      failures++; $display("FAIL drop_rx_timeout got %0d frames want %0d", rx_q.size(), f + 1);
    end else if (rx_q[f] !== {l1, r1}) begin
      failures++; $display("FAIL drop_frame got %h want %h", rx_q[f], {l1, r1});
    end
  endtask

  task automatic test_repeat();
    int f, n_und;
    n_und = 0;
    tick(1'b1, 24'h7FFFFF, 24'h800000);
    f = int'(t / 2048) + 1;
    for (int i = 0; i < 11000 && rx_q.size() < f + 4; i++) begin
      tick(1'b0, 24'd0, 24'd0);
      if (bus.undrrn === 1'b1) n_und++;
    end
    checks++;
    if (rx_q.size() < f + 4) begin
      failures++; $display("FAIL rep_rx_timeout got %0d frames want %0d", rx_q.size(), f + 4);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rx_q[f + k] !== 48'h7FFFFF_800000) begin
          failures++; $display("FAIL rep_frame%0d got %h want 7fffff800000", k, rx_q[f + k]);
        end
      end
    end
    checks++;
    if (n_und != 3) begin failures++; $display("FAIL rep_undrrn_count got %0d want 3", n_und); end
  endtask

  task automatic test_wrt_on_transfer();
    logic [23:0] l, r;
    int m;
    l = 24'($urandom); r = 24'($urandom);
    for (int i = 0; i < 2100 && ((t + 1) % 2048) != 0; i++) tick(1'b0, 24'd0, 24'd0);
    tick(1'b1, l, r);
    m = int'(t / 2048);
    checks += 3;
    if (bus.undrrn !== 1'b1) begin failures++; $display("FAIL wot_undrrn t=%0d got %b want 1", t, bus.undrrn); end
    if (bus.frm_strt !== 1'b1) begin failures++; $display("FAIL wot_frm_strt t=%0d got %b want 1", t, bus.frm_strt); end
    if (bus.buf_full !== 1'b1) begin failures++; $display("FAIL wot_buf_full t=%0d got %b want 1", t, bus.buf_full); end
    for (int i = 0; i < 6000 && rx_q.size() < m + 2; i++) tick(1'b0, 24'd0, 24'd0);
    checks++;
    if (rx_q.size() < m + 2) begin
      failures++; $display("FAIL wot_rx_timeout got %0d frames want %0d", rx_q.size(), m + 2);
    end else begin
      checks++;
      if (rx_q[m] !== 48'h7FFFFF_800000) begin failures++; $display("FAIL wot_repeat got %h want 7fffff800000", rx_q[m]); end
      if (rx_q[m + 1] !== {l, r}) begin failures++; $display("FAIL wot_new got %h want %h", rx_q[m + 1], {l, r}); end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 2100 && ((t % 2048) / 32) != 39; i++) tick(1'b0, 24'd0, 24'd0);
    tick(1'b1, 24'($urandom), 24'($urandom));
    for (int i = 0; i < 100 && !(((t % 2048) / 32) == 40 && (t % 32) == 20); i++) tick(1'b0, 24'd0, 24'd0);
    #2 rst_n = 1'b0;
    #1;
    checks += 6;
    if (bus.I2S_sclk !== 1'b0) begin failures++; $display("FAIL mrst_sclk got %b want 0", bus.I2S_sclk); end
    if (bus.I2S_ws   !== 1'b0) begin failures++; $display("FAIL mrst_ws got %b want 0", bus.I2S_ws); end
    if (bus.I2S_data !== 1'b0) begin failures++; $display("FAIL mrst_data got %b want 0", bus.I2S_data); end
    if (bus.buf_full !== 1'b0) begin failures++; $display("FAIL mrst_buf_full got %b want 0", bus.buf_full); end
    if (bus.undrrn   !== 1'b0) begin failures++; $display("FAIL mrst_undrrn got %b want 0", bus.undrrn); end
    if (bus.frm_strt !== 1'b0) begin failures++; $display("FAIL mrst_frm_strt got %b want 0", bus.frm_strt); end
    release_reset();
    repeat (5) tick(1'b0, 24'd0, 24'd0);
    checks++;
    if (bus.I2S_ws !== 1'b0) begin failures++; $display("FAIL mrst_ws_after got %b want 0", bus.I2S_ws); end
    while (t < 2047) tick(1'b0, 24'd0, 24'd0);
    checks++;
    if (bus.frm_strt !== 1'b0) begin failures++; $display("FAIL mrst_early_xfer t=%0d got %b want 0", t, bus.frm_strt); end
    tick(1'b0, 24'd0, 24'd0);
    checks += 3;
    if (bus.frm_strt !== 1'b1) begin failures++; $display("FAIL mrst_first_xfer t=%0d got %b want 1", t, bus.frm_strt); end
    if (bus.undrrn !== 1'b1) begin failures++; $display("FAIL mrst_first_undrrn t=%0d got %b want 1", t, bus.undrrn); end
    if (rx_q.size() < 1 || rx_q[0] !== 48'h0) begin
      failures++; $display("FAIL mrst_frame0 got %0d frames want zero frame", rx_q.size());
    end
  endtask

  task automatic test_random_loopback();
    localparam int N = 16;
    logic [47:0] sent[$];
    int k, f0, delay, n_und, n_frm;
    logic        w;
    logic [23:0] l, r;
    k = 0; f0 = 0; n_und = 0; n_frm = 0;
    delay = int'($urandom_range(0, 400));
    for (int cyc = 0; cyc < N * 2048 + 4096 && (k < N || rx_q.size() < f0 + N); cyc++) begin
      w = 1'b0; l = 24'd0; r = 24'd0;
      if (k < N && bus.buf_full === 1'b0) begin
        if (delay == 0) begin
          w = 1'b1; l = 24'($urandom); r = 24'($urandom);
        end else begin
          delay--;
        end
      end
      tick(w, l, r);
      if (w) begin
        sent.push_back({l, r});
        if (k == 0) f0 = int'(t / 2048) + 1;
        k++;
        delay = int'($urandom_range(0, 400));
      end
      if (k > 0 && bus.undrrn === 1'b1) n_und++;
      if (k > 0 && bus.frm_strt === 1'b1) n_frm++;
      checks += 3;
      if (bus.I2S_data !== exp_data()) begin failures++; $display("FAIL rnd_data t=%0d got %b want %b", t, bus.I2S_data, exp_data()); end
      if (bus.I2S_ws !== exp_ws()) begin failures++; $display("FAIL rnd_ws t=%0d got %b want %b", t, bus.I2S_ws, exp_ws()); end
      if (bus.buf_full !== mdl_full) begin failures++; $display("FAIL rnd_buf_full t=%0d got %b want %b", t, bus.buf_full, mdl_full); end
    end
    checks++;
    if (k < N || rx_q.size() < f0 + N) begin
      failures++; $display("FAIL rnd_timeout got %0d writes %0d frames want %0d writes %0d frames", k, rx_q.size(), N, f0 + N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (rx_q[f0 + i] !== sent[i]) begin failures++; $display("FAIL rnd_pair%0d got %h want %h", i, rx_q[f0 + i], sent[i]); end
      end
    end
    checks += 2;
    if (n_und != 0) begin failures++; $display("FAIL rnd_undrrn_count got %0d want 0", n_und); end
    if (n_frm != N) begin failures++; $display("FAIL rnd_frm_count got %0d want %0d", n_frm, N); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wrt       = 1'b0;
    bus.lft_smpl  = 24'd0;
    bus.rght_smpl = 24'd0;
    test_reset();
    test_idle();
    test_first_frame();
    test_drop();
    test_repeat();
    test_wrt_on_transfer();
    test_mid_reset();
    test_random_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
